// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution stage: condition codes
// and bit positions inside the {N,Z,C,V} flag register.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: decides whether an instruction
// with the given condition field executes under the supplied flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = ~z & c;
            COND_LS: cond_ex = z | ~c;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            // The reserved encoding behaves as "always".
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field
// against the registered flags and gates the decoder strobes accordingly.
module cond_unit
    import cond_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              pcs,
    input  logic              reg_w,
    input  logic              mem_w,
    input  logic [1:0]        flag_w,
    input  logic              no_write,
    input  logic              stall,
    output logic              pc_src,
    output logic              reg_write,
    output logic              mem_write,
    output logic [FLAG_W-1:0] flags,
    output logic              cond_ex
);

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       go;
    logic       nz_en;
    logic       cv_en;

    assign flags = {nz_q, cv_q};

    // Evaluated against the registered flags, so a flag-setting conditional
    // instruction always tests the flags from before its own update.
    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign go        = cond_ex & ~stall;
    assign pc_src    = pcs & go;
    assign reg_write = reg_w & ~no_write & go;
    assign mem_write = mem_w & go;
    assign nz_en     = flag_w[1] & go;
    assign cv_en     = flag_w[0] & go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nz_q <= 2'b00;
        end else if (nz_en) begin
            nz_q <= alu_flags[FLAG_N:FLAG_Z];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cv_q <= 2'b00;
        end else if (cv_en) begin
            cv_q <= alu_flags[FLAG_C:FLAG_V];
        end
    end

endmodule
